// File: rtl/traffic_phase_arbiter_if.sv
// Detector/preemption inputs and lamp/status outputs of the traffic phase arbiter.
interface traffic_phase_arbiter_if;
    logic [3:0] req;
    logic       emerg_valid;
    logic [1:0] emerg_dir;
    logic [2:0] north_lights;
    logic [2:0] east_lights;
    logic [2:0] south_lights;
    logic [2:0] west_lights;
    logic [1:0] active_dir;
    logic [3:0] pend;

    modport master (
        output req, emerg_valid, emerg_dir,
        input  north_lights, east_lights, south_lights, west_lights, active_dir, pend
    );

    modport slave (
        input  req, emerg_valid, emerg_dir,
        output north_lights, east_lights, south_lights, west_lights, active_dir, pend
    );
endinterface

// File: rtl/traffic_phase_arbiter.sv
// Four-approach traffic phase arbiter: round-robin green allocation with min/max
// green timing, yellow and all-red clearance, and emergency preemption.
module traffic_phase_arbiter #(
    parameter int MIN_GREEN = 10,
    parameter int MAX_GREEN = 30,
    parameter int YELLOW_T  = 5,
    parameter int CLEAR_T   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    traffic_phase_arbiter_if.slave bus
);
    localparam int TMAX0 = (MAX_GREEN > YELLOW_T) ? MAX_GREEN : YELLOW_T;
    localparam int TMAX  = (TMAX0 > CLEAR_T) ? TMAX0 : CLEAR_T;
    localparam int TW    = $clog2(TMAX + 1);

    localparam logic [TW-1:0] MIN_LAST = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_LAST = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] MAX_SAT  = TW'(MAX_GREEN);
    localparam logic [TW-1:0] YEL_LAST = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] CLR_LAST = TW'(CLEAR_T - 1);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    typedef enum logic [1:0] {IDLE, GREEN, YELLOW, CLEAR} state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [3:0]      pend;
    logic [1:0]      last;
    logic [1:0]      active_dir;
    logic [3:0][2:0] lamps;

    logic [1:0] rr_dir;
    logic [1:0] sel_dir;
    logic       sel_valid;
    logic       other_pend;
    logic       enter_green;
    logic [3:0] green_mask;
    logic [3:0] enter_mask;
    logic [3:0] pend_nxt;

    function automatic logic [3:0][2:0] drive(input logic [2:0] color, input logic [1:0] dir);
        logic [3:0][2:0] l;
        l      = {4{RED}};
        l[dir] = color;
        return l;
    endfunction

    // Nearest pending approach after the last served one wins; scanning from the
    // farthest offset down lets the closest hit overwrite the others.
    always_comb begin
        rr_dir = last;
        for (int i = 4; i >= 1; i--) begin
            if (pend[last + 2'(i)]) rr_dir = last + 2'(i);
        end
    end

    assign sel_valid   = bus.emerg_valid | (|pend);
    assign sel_dir     = bus.emerg_valid ? bus.emerg_dir : rr_dir;
    assign other_pend  = |(pend & ~(4'b0001 << active_dir));
    assign enter_green = sel_valid && ((state == IDLE) || (state == CLEAR && timer == CLR_LAST));
    assign enter_mask  = enter_green ? (4'b0001 << sel_dir) : 4'b0000;

    // Detector pulses on the approach that is green are not latched while it stays green.
    assign green_mask  = (state == GREEN) ? (4'b0001 << active_dir) : 4'b0000;
    assign pend_nxt    = (pend | (bus.req & ~green_mask)) & ~enter_mask;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            timer      <= '0;
            pend       <= '0;
            last       <= 2'd3;
            active_dir <= 2'd0;
            lamps      <= {4{RED}};
        end else begin
            pend  <= pend_nxt;
            timer <= (timer == MAX_SAT) ? timer : timer + 1'b1;
            if (enter_green) begin
                state      <= GREEN;
                timer      <= '0;
                active_dir <= sel_dir;
                last       <= sel_dir;
                lamps      <= drive(GRN, sel_dir);
            end else begin
                case (state)
                    GREEN: begin
                        if (bus.emerg_valid && bus.emerg_dir == active_dir) begin
                            timer <= '0;
                        end else if (bus.emerg_valid ||
                                     (other_pend && (timer >= MIN_LAST || timer == MAX_LAST))) begin
                            state <= YELLOW;
                            timer <= '0;
                            lamps <= drive(YEL, active_dir);
                        end
                    end
                    YELLOW: begin
                        if (timer == YEL_LAST) begin
                            state <= CLEAR;
                            timer <= '0;
                            lamps <= {4{RED}};
                        end
                    end
                    CLEAR: begin
                        // Reaching here at the last clearance cycle means nothing is waiting.
                        if (timer == CLR_LAST) begin
                            state <= IDLE;
                            timer <= '0;
                            lamps <= {4{RED}};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.north_lights = lamps[0];
    assign bus.east_lights  = lamps[1];
    assign bus.south_lights = lamps[2];
    assign bus.west_lights  = lamps[3];
    assign bus.active_dir   = active_dir;
    assign bus.pend         = pend;
endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Randomized and directed stimulus for traffic_phase_arbiter, compared every cycle
// against a phase-level behavioural model of the intersection.
module tb_traffic_phase_arbiter;
    localparam int MIN_GREEN = 10;
    localparam int MAX_GREEN = 30;
    localparam int YELLOW_T  = 5;
    localparam int CLEAR_T   = 2;
    localparam logic [11:0] ALL_RED = 12'h924;

    localparam int P_IDLE   = 0;
    localparam int P_GREEN  = 1;
    localparam int P_YELLOW = 2;
    localparam int P_CLEAR  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    traffic_phase_arbiter_if bus();

    traffic_phase_arbiter #(
        .MIN_GREEN(MIN_GREEN),
        .MAX_GREEN(MAX_GREEN),
        .YELLOW_T (YELLOW_T),
        .CLEAR_T  (CLEAR_T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: which phase the intersection is in, how long it has been there,
    // who holds it, who was served last and who is waiting.
    int         m_phase = P_IDLE;
    int         m_age   = 0;
    int         m_dir   = 0;
    int         m_last  = 3;
    logic [3:0] m_pend  = 4'b0000;

    function automatic int rr_pick(input logic [3:0] p, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (((p >> ((last + k) % 4)) & 4'b0001) != 4'b0000) return (last + k) % 4;
        end
        return last;
    endfunction

    task automatic m_reset();
        m_phase = P_IDLE;
        m_age   = 0;
        m_dir   = 0;
        m_last  = 3;
        m_pend  = 4'b0000;
    endtask

    task automatic m_step();
        logic [3:0] np;
        bit         want;
        bit         others;
        int         pick;
        bit         enter;
        np     = m_pend | ((m_phase == P_GREEN) ? (bus.req & ~(4'b0001 << m_dir)) : bus.req);
        want   = bus.emerg_valid || (m_pend != 4'b0000);
        pick   = bus.emerg_valid ? int'(bus.emerg_dir) : rr_pick(m_pend, m_last);
        others = (m_pend & ~(4'b0001 << m_dir)) != 4'b0000;
        enter  = 1'b0;
        case (m_phase)
            P_IDLE: enter = want;
            P_GREEN: begin
                if (bus.emerg_valid && int'(bus.emerg_dir) == m_dir) begin
                    m_age = 0;
                end else if (bus.emerg_valid || (others && m_age + 1 >= MIN_GREEN)) begin
                    m_phase = P_YELLOW;
                    m_age   = 0;
                end else begin
                    m_age++;
                end
            end
            P_YELLOW: begin
                if (m_age + 1 == YELLOW_T) begin
                    m_phase = P_CLEAR;
                    m_age   = 0;
                end else begin
                    m_age++;
                end
            end
            default: begin
                if (m_age + 1 == CLEAR_T) begin
                    if (want) enter = 1'b1;
                    else begin
                        m_phase = P_IDLE;
                        m_age   = 0;
                    end
                end else begin
                    m_age++;
                end
            end
        endcase
        if (enter) begin
            m_phase = P_GREEN;
            m_age   = 0;
            m_dir   = pick;
            m_last  = pick;
            np      = np & ~(4'b0001 << pick);
        end
        m_pend = np;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) m_reset();
        else      m_step();
    end

    function automatic logic [11:0] m_lamps();
        logic [11:0] l;
        l = ALL_RED;
        if (m_phase == P_GREEN)  l = (l & ~(12'h7 << (3 * m_dir))) | (12'h1 << (3 * m_dir));
        if (m_phase == P_YELLOW) l = (l & ~(12'h7 << (3 * m_dir))) | (12'h2 << (3 * m_dir));
        return l;
    endfunction

    // Lamp words that are not one-hot, plus one if more than one approach is not red.
    function automatic int lamp_faults(input logic [11:0] l);
        int         nonred;
        int         bad;
        logic [2:0] lamp;
        nonred = 0;
        bad    = 0;
        for (int k = 0; k < 4; k++) begin
            lamp = 3'(l >> (3 * k));
            if (!$onehot(lamp)) bad++;
            if (lamp != 3'b100) nonred++;
        end
        return bad + ((nonred > 1) ? 1 : 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] dut_lamps();
        return {bus.west_lights, bus.south_lights, bus.east_lights, bus.north_lights};
    endfunction

    task automatic compare_all();
        chk("lamps", 32'(dut_lamps()), 32'(m_lamps()));
        chk("active_dir", 32'(bus.active_dir), 32'(m_dir));
        chk("pend", 32'(bus.pend), 32'(m_pend));
        chk("exclusive", 32'(lamp_faults(dut_lamps())), 32'd0);
    endtask

    task automatic apply(input logic [3:0] r, input logic v, input logic [1:0] d);
        @(negedge clk);
        compare_all();
        bus.req         = r;
        bus.emerg_valid = v;
        bus.emerg_dir   = d;
    endtask

    // Called just after a falling clock edge; the pulse completes before the next rising edge.
    task automatic async_reset();
        #1 rst = 1'b0;
        #1;
        chk("arst_lamps", 32'(dut_lamps()), 32'(ALL_RED));
        chk("arst_pend", 32'(bus.pend), 32'd0);
        compare_all();
        #1 rst = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        logic [1:0] ed;
        int         emerg_left;
        int         mode;
        bit         ok;

        bus.req         = 4'b0000;
        bus.emerg_valid = 1'b0;
        bus.emerg_dir   = 2'd0;
        repeat (3) @(negedge clk);
        chk("por_lamps", 32'(dut_lamps()), 32'(ALL_RED));
        chk("por_pend", 32'(bus.pend), 32'd0);
        chk("por_active", 32'(bus.active_dir), 32'd0);
        rst = 1'b1;

        // Single N pulse: latched after one edge, N green after the second.
        apply(4'b0001, 1'b0, 2'd0);
        apply(4'b0000, 1'b0, 2'd0);
        chk("pend_n", 32'(bus.pend), 32'd1);
        apply(4'b0000, 1'b0, 2'd0);
        chk("n_green", 32'(bus.north_lights), 32'(3'b001));
        chk("n_pend_clr", 32'(bus.pend), 32'd0);
        repeat (20) apply(4'b0000, 1'b0, 2'd0);
        chk("n_hold", 32'(bus.north_lights), 32'(3'b001));

        // E request arriving a few cycles into N green.
        async_reset();
        apply(4'b0001, 1'b0, 2'd0);
        repeat (5) apply(4'b0000, 1'b0, 2'd0);
        apply(4'b0010, 1'b0, 2'd0);
        repeat (40) apply(4'b0000, 1'b0, 2'd0);
        chk("e_green", 32'(bus.east_lights), 32'(3'b001));

        // All four approaches at once.
        async_reset();
        apply(4'b1111, 1'b0, 2'd0);
        repeat (90) apply(4'b0000, 1'b0, 2'd0);

        // Emergency for E while S is early in its green; a competing N request must wait.
        async_reset();
        apply(4'b0100, 1'b0, 2'd0);
        repeat (4) apply(4'b0000, 1'b0, 2'd0);
        repeat (12) apply(4'b0000, 1'b1, 2'd1);
        apply(4'b0001, 1'b1, 2'd1);
        repeat (25) apply(4'b0000, 1'b1, 2'd1);
        chk("emerg_e_hold", 32'(bus.east_lights), 32'(3'b001));
        repeat (30) apply(4'b0000, 1'b0, 2'd0);

        // Reset while yellow.
        async_reset();
        apply(4'b0001, 1'b0, 2'd0);
        repeat (3) apply(4'b0000, 1'b0, 2'd0);
        apply(4'b0010, 1'b0, 2'd0);
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            apply(4'b0000, 1'b0, 2'd0);
            ok = (m_phase == P_YELLOW);
        end
        chk("reach_yellow", 32'(ok), 32'd1);
        async_reset();
        repeat (5) apply(4'b0000, 1'b0, 2'd0);
        chk("idle_after_rst", 32'(dut_lamps()), 32'(ALL_RED));

        // Continuous W with occasional N.
        async_reset();
        for (int i = 0; i < 150; i++) begin
            apply(((i % 40) == 15) ? 4'b1001 : 4'b1000, 1'b0, 2'd0);
        end

        // Randomized traffic: sparse, dense, and continuous-W windows with emergency bursts.
        emerg_left = 0;
        mode       = 0;
        ed         = 2'd0;
        for (int c = 0; c < 4000; c++) begin
            if ((c % 250) == 0) mode = int'($urandom_range(0, 2));
            r = 4'b0000;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, (mode == 1) ? 3 : 24) == 0) r[b] = 1'b1;
            end
            if (mode == 2) r[3] = 1'b1;
            if (emerg_left == 0 && $urandom_range(0, 149) == 0) begin
                emerg_left = int'($urandom_range(3, 50));
                ed         = 2'($urandom_range(0, 3));
            end
            apply(r, emerg_left != 0, ed);
            if (emerg_left != 0) emerg_left--;
            if ($urandom_range(0, 599) == 0) async_reset();
        end
        apply(4'b0000, 1'b0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
